// File: rtl/timer_readout_pkg.sv
// Shared types and constants for the timer readout controller.
// Contents: FSM state enum, result-record word indices, record length.
// Optional feature macro: TIMER_READOUT_AVG_EN (adds an average word to the record).
package timer_readout_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StArm,
    StWait,
    StCapture,
    StReport
  } state_e;

  // Result record word indices, in emission order.
  localparam logic [2:0] W_CNT = 3'd0;
  localparam logic [2:0] W_MIN = 3'd1;
  localparam logic [2:0] W_MAX = 3'd2;
  localparam logic [2:0] W_SUM = 3'd3;
  localparam logic [2:0] W_AVG = 3'd4;

`ifdef TIMER_READOUT_AVG_EN
  localparam int unsigned RES_WORDS = 5;
`else
  localparam int unsigned RES_WORDS = 4;
`endif

  localparam logic [2:0] W_LAST = 3'(RES_WORDS - 1);

endpackage

// File: rtl/timer_stat_acc.sv
// Running statistics over timer captures: minimum, maximum and saturating sum.
// Ports:
//   clk, rst_n  - clock, synchronous active-low reset
//   clr_i       - restart statistics (min=all-ones, max=0, sum=0)
//   upd_i       - fold val_i into the statistics
//   val_i       - captured timer value
//   min_o/max_o/sum_o - current statistics
module timer_stat_acc #(
  parameter int unsigned TW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          upd_i,
  input  logic [TW-1:0] val_i,
  output logic [TW-1:0] min_o,
  output logic [TW-1:0] max_o,
  output logic [TW-1:0] sum_o
);

  logic [TW-1:0] min_d, min_q;
  logic [TW-1:0] max_d, max_q;
  logic [TW-1:0] sum_d, sum_q;
  logic [TW:0]   sum_ext;

  always_comb begin
    min_d   = min_q;
    max_d   = max_q;
    sum_d   = sum_q;
    sum_ext = {1'b0, sum_q} + {1'b0, val_i};
    if (clr_i) begin
      min_d = '1;
      max_d = '0;
      sum_d = '0;
    end else if (upd_i) begin
      if (val_i < min_q) min_d = val_i;
      if (val_i > max_q) max_d = val_i;
      // Carry out of the TW-bit add means overflow: clamp to all-ones.
      sum_d = sum_ext[TW] ? '1 : sum_ext[TW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      min_q <= '1;
      max_q <= '0;
      sum_q <= '0;
    end else begin
      min_q <= min_d;
      max_q <= max_d;
      sum_q <= sum_d;
    end
  end

  assign min_o = min_q;
  assign max_o = max_q;
  assign sum_o = sum_q;

endmodule

// File: rtl/timer_readout.sv
// Batch controller and reader for a cycle-measurement timer. Restarts the timer RUNS times via
// its reset, captures tim on finish, reduces to count/min/max/sum and streams the record over a
// valid/ready port.
// Ports:
//   clk, rst_n             - clock, synchronous active-low reset
//   start                  - pulse, begins a batch when idle
//   busy                   - batch in progress (until last word handshake)
//   tmr_rst_n              - registered reset to the timer (low = hold/restart)
//   tmr_finish, tmr_tim    - timer done flag and elapsed count
//   res_valid/ready/data/last - result word stream
//   err_timeout            - some run in this batch hit the watchdog
// Optional feature macro: TIMER_READOUT_AVG_EN appends word 4 = sum >> log2(RUNS).
module timer_readout
  import timer_readout_pkg::*;
#(
  parameter int unsigned TW      = 32,
  parameter int unsigned RUNS    = 4,
  parameter int unsigned TIMEOUT = 4096
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  output logic          busy,
  output logic          tmr_rst_n,
  input  logic          tmr_finish,
  input  logic [TW-1:0] tmr_tim,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [TW-1:0] res_data,
  output logic          res_last,
  output logic          err_timeout
);

  localparam int unsigned CntW = $clog2(RUNS + 1);
  localparam int unsigned WdW  = $clog2(TIMEOUT + 1);
`ifdef TIMER_READOUT_AVG_EN
  localparam int unsigned RunsLog2 = $clog2(RUNS);
`endif

  state_e          state_d, state_q;
  logic [CntW-1:0] run_cnt_d, run_cnt_q;
  logic [WdW-1:0]  wdog_d, wdog_q;
  logic [TW-1:0]   tim_d, tim_q;
  logic [2:0]      widx_d, widx_q;
  logic            busy_d, busy_q;
  logic            tmr_rst_n_d, tmr_rst_n_q;
  logic            res_valid_d, res_valid_q;
  logic [TW-1:0]   res_data_d, res_data_q;
  logic            res_last_d, res_last_q;
  logic            err_d, err_q;

  logic            acc_clr, acc_upd;
  logic [TW-1:0]   acc_min, acc_max, acc_sum;
  logic [CntW-1:0] cnt_inc;
  logic [2:0]      sel_idx;
  logic [TW-1:0]   sel_word;

  timer_stat_acc #(
    .TW(TW)
  ) u_acc (
    .clk  (clk),
    .rst_n(rst_n),
    .clr_i(acc_clr),
    .upd_i(acc_upd),
    .val_i(tim_q),
    .min_o(acc_min),
    .max_o(acc_max),
    .sum_o(acc_sum)
  );

  assign cnt_inc = run_cnt_q + CntW'(1);

  // Word to load next: word 0 on REPORT entry, otherwise the one after the word on the bus.
  always_comb begin
    sel_idx  = res_valid_q ? (widx_q + 3'd1) : W_CNT;
    sel_word = '0;
    case (sel_idx)
      W_CNT:   sel_word = TW'(run_cnt_q);
      W_MIN:   sel_word = acc_min;
      W_MAX:   sel_word = acc_max;
      W_SUM:   sel_word = acc_sum;
`ifdef TIMER_READOUT_AVG_EN
      W_AVG:   sel_word = acc_sum >> RunsLog2;
`endif
      default: sel_word = '0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    run_cnt_d   = run_cnt_q;
    wdog_d      = wdog_q;
    tim_d       = tim_q;
    widx_d      = widx_q;
    busy_d      = busy_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    res_last_d  = res_last_q;
    err_d       = err_q;
    acc_clr     = 1'b0;
    acc_upd     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d   = StArm;
          run_cnt_d = '0;
          err_d     = 1'b0;
          acc_clr   = 1'b1;
          busy_d    = 1'b1;
        end
      end
      StArm: begin
        wdog_d  = '0;
        state_d = StWait;
      end
      StWait: begin
        wdog_d = wdog_q + WdW'(1);
        // Finish takes priority over a watchdog expiry in the same cycle.
        if (tmr_finish) begin
          tim_d   = tmr_tim;
          state_d = StCapture;
        end else if (wdog_q == WdW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = StReport;
        end
      end
      StCapture: begin
        acc_upd   = 1'b1;
        run_cnt_d = cnt_inc;
        state_d   = (cnt_inc == CntW'(RUNS)) ? StReport : StArm;
      end
      StReport: begin
        if (!res_valid_q) begin
          res_valid_d = 1'b1;
          widx_d      = sel_idx;
          res_data_d  = sel_word;
          res_last_d  = (sel_idx == W_LAST);
        end else if (res_ready) begin
          if (res_last_q) begin
            res_valid_d = 1'b0;
            res_last_d  = 1'b0;
            busy_d      = 1'b0;
            state_d     = StIdle;
          end else begin
            widx_d     = sel_idx;
            res_data_d = sel_word;
            res_last_d = (sel_idx == W_LAST);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // Registered so the timer sees reset through ARM plus the cycle before it.
    tmr_rst_n_d = (state_d == StWait);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      run_cnt_q   <= '0;
      wdog_q      <= '0;
      tim_q       <= '0;
      widx_q      <= W_CNT;
      busy_q      <= 1'b0;
      tmr_rst_n_q <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_last_q  <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      wdog_q      <= wdog_d;
      tim_q       <= tim_d;
      widx_q      <= widx_d;
      busy_q      <= busy_d;
      tmr_rst_n_q <= tmr_rst_n_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_last_q  <= res_last_d;
      err_q       <= err_d;
    end
  end

  assign busy        = busy_q;
  assign tmr_rst_n   = tmr_rst_n_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign res_last    = res_last_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_timer_readout.sv
// Scoreboard bench for timer_readout: expected records are queued at start, monitors compare
// every handshaked word. Two instances: 32-bit (main tests) and 8-bit (sum saturation).
module tb_timer_readout;

  localparam int F   = 100;
  localparam int FB  = 5;
  localparam int LAT = 4 * (F + 2) + 2;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, busy, tmr_rst_n, tmr_finish, res_valid, res_ready, res_last, err_timeout;
  logic [31:0] tmr_tim, res_data;

  logic        b_start, b_busy, b_tmr_rst_n, b_tmr_finish, b_res_valid, b_res_ready, b_res_last;
  logic        b_err_timeout;
  logic [7:0]  b_tmr_tim, b_res_data;

  int errors = 0;
  int checks = 0;

  word_t q_a[$];
  word_t q_b[$];

  // Timer model state
  int          mcnt = 0;
  int          run_idx = 0;
  logic        running = 1'b0;
  logic        mdl_clr = 1'b0;
  logic        mdl_fin_en = 1'b1;
  logic [31:0] tims[4];
  int          b_mcnt = 0;

  // Backpressure handshaking bookkeeping
  logic        bp_mode = 1'b0;
  int          hs_count = 0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data = '0;
  logic        prev_last = 1'b0;

  always #5 clk = ~clk;

  timer_readout #(.TW(32), .RUNS(4), .TIMEOUT(4096)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .busy       (busy),
    .tmr_rst_n  (tmr_rst_n),
    .tmr_finish (tmr_finish),
    .tmr_tim    (tmr_tim),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
    .res_last   (res_last),
    .err_timeout(err_timeout)
  );

  timer_readout #(.TW(8), .RUNS(4), .TIMEOUT(64)) u_dut_b (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (b_start),
    .busy       (b_busy),
    .tmr_rst_n  (b_tmr_rst_n),
    .tmr_finish (b_tmr_finish),
    .tmr_tim    (b_tmr_tim),
    .res_valid  (b_res_valid),
    .res_ready  (b_res_ready),
    .res_data   (b_res_data),
    .res_last   (b_res_last),
    .err_timeout(b_err_timeout)
  );

  // Timer model: counts cycles of released reset, finish in the F-th such cycle.
  always @(posedge clk) begin
    if (mdl_clr) run_idx <= 0;
    else if (!tmr_rst_n && running) run_idx <= run_idx + 1;
    if (!tmr_rst_n) begin
      mcnt    <= 0;
      running <= 1'b0;
    end else begin
      running <= 1'b1;
      if (mcnt < F - 1) mcnt <= mcnt + 1;
    end
  end
  assign tmr_finish = mdl_fin_en && tmr_rst_n && (mcnt == F - 1);
  assign tmr_tim    = tims[run_idx[1:0]];

  always @(posedge clk) begin
    if (!b_tmr_rst_n) b_mcnt <= 0;
    else if (b_mcnt < FB - 1) b_mcnt <= b_mcnt + 1;
  end
  assign b_tmr_finish = b_tmr_rst_n && (b_mcnt == FB - 1);
  assign b_tmr_tim    = 8'd200;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor for the 32-bit instance: stall stability plus scoreboard pop on handshake.
  always @(negedge clk) begin
    word_t w;
    if (prev_stall) begin
      check("stall_valid", {31'b0, res_valid}, 32'd1);
      check("stall_data", res_data, prev_data);
      check("stall_last", {31'b0, res_last}, {31'b0, prev_last});
    end
    prev_stall = res_valid && !res_ready;
    prev_data  = res_data;
    prev_last  = res_last;
    if (res_valid && res_ready) begin
      hs_count++;
      if (q_a.size() == 0) begin
        check("unexpected_word_a", res_data, 32'hDEAD_BEEF);
      end else begin
        w = q_a.pop_front();
        check("word_a_data", res_data, w.data);
        check("word_a_last", {31'b0, res_last}, {31'b0, w.last});
      end
    end
  end

  always @(negedge clk) begin
    word_t w;
    if (b_res_valid && b_res_ready) begin
      if (q_b.size() == 0) begin
        check("unexpected_word_b", {24'b0, b_res_data}, 32'hDEAD_BEEF);
      end else begin
        w = q_b.pop_front();
        check("word_b_data", {24'b0, b_res_data}, w.data);
        check("word_b_last", {31'b0, b_res_last}, {31'b0, w.last});
      end
    end
  end

  // Ready driver: in backpressure mode each word is held off for at least 5 cycles.
  initial begin
    int bp_cnt = 0;
    int seen = 0;
    res_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (hs_count != seen) begin
        seen   = hs_count;
        bp_cnt = 0;
      end else if (res_valid) begin
        bp_cnt++;
      end
      res_ready = !bp_mode || (bp_cnt > 5);
    end
  end

  task automatic push_rec(input logic [31:0] c, input logic [31:0] mn, input logic [31:0] mx,
                          input logic [31:0] sm, input logic [31:0] av, input bit is_b);
    word_t w[5];
    w[0] = '{c, 1'b0};
    w[1] = '{mn, 1'b0};
    w[2] = '{mx, 1'b0};
`ifdef TIMER_READOUT_AVG_EN
    w[3] = '{sm, 1'b0};
    w[4] = '{av, 1'b1};
    for (int i = 0; i < 5; i++) begin
`else
    w[3] = '{sm, 1'b1};
    w[4] = '{av, 1'b0};
    for (int i = 0; i < 4; i++) begin
`endif
      if (is_b) q_b.push_back(w[i]);
      else q_a.push_back(w[i]);
    end
  endtask

  task automatic set_tims(input logic [31:0] t0, input logic [31:0] t1, input logic [31:0] t2,
                          input logic [31:0] t3);
    tims[0] = t0;
    tims[1] = t1;
    tims[2] = t2;
    tims[3] = t3;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1;
    start   = 1'b1;
    mdl_clr = 1'b1;
    @(posedge clk);
    #1;
    start   = 1'b0;
    mdl_clr = 1'b0;
    check("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int bound, input logic exp_err);
    int n = 0;
    while (busy && n < bound) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_in_time"}, {31'b0, busy}, 32'd0);
    check({name, "_err"}, {31'b0, err_timeout}, {31'b0, exp_err});
    check({name, "_queue_empty"}, q_a.size(), 32'd0);
  endtask

  initial begin
    int n;
    rst_n   = 1'b0;
    start   = 1'b0;
    b_start = 1'b0;
    b_res_ready = 1'b1;
    set_tims(99, 99, 99, 99);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_tmr_rst_n", {31'b0, tmr_rst_n}, 32'd0);
    check("rst_res_valid", {31'b0, res_valid}, 32'd0);
    check("rst_res_data", res_data, 32'd0);
    check("rst_res_last", {31'b0, res_last}, 32'd0);
    check("rst_err", {31'b0, err_timeout}, 32'd0);
    check("rst_b_res_data", {24'b0, b_res_data}, 32'd0);
    rst_n = 1'b1;

    // Basic batch, with start-to-first-word latency.
    push_rec(4, 99, 99, 396, 99, 1'b0);
    pulse_start();
    n = 1;
    while (!res_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("latency_in_window", {31'b0, (n >= LAT - 1) && (n <= LAT + 1)}, 32'd1);
    wait_done("basic", 3000, 1'b0);

    // Varying captures.
    set_tims(10, 50, 30, 70);
    push_rec(4, 10, 70, 160, 40, 1'b0);
    pulse_start();
    wait_done("varying", 3000, 1'b0);

    // Timeout on the first run: empty record.
    mdl_fin_en = 1'b0;
    push_rec(0, 32'hFFFF_FFFF, 0, 0, 0, 1'b0);
    pulse_start();
    wait_done("timeout", 6000, 1'b1);

    // Following normal batch clears err_timeout at start.
    mdl_fin_en = 1'b1;
    set_tims(99, 99, 99, 99);
    push_rec(4, 99, 99, 396, 99, 1'b0);
    pulse_start();
    check("err_cleared_at_start", {31'b0, err_timeout}, 32'd0);
    wait_done("second", 3000, 1'b0);

    // Backpressure, with a start pulse during REPORT that must be ignored.
    bp_mode = 1'b1;
    set_tims(10, 50, 30, 70);
    push_rec(4, 10, 70, 160, 40, 1'b0);
    pulse_start();
    n = 0;
    while (!res_valid && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (2) @(posedge clk);
    #1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done("backpressure", 3000, 1'b0);
    repeat (5) @(negedge clk);
    check("no_restart_from_report", {31'b0, busy}, 32'd0);
    bp_mode = 1'b0;

    // 8-bit saturation.
    push_rec(4, 200, 200, 255, 63, 1'b1);
    @(posedge clk);
    #1;
    b_start = 1'b1;
    @(posedge clk);
    #1;
    b_start = 1'b0;
    n = 0;
    while (b_busy && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("sat_done_in_time", {31'b0, b_busy}, 32'd0);
    check("sat_queue_empty", q_b.size(), 32'd0);

    // Reset during WAIT of run 2, then a clean batch.
    set_tims(10, 50, 30, 70);
    pulse_start();
    n = 0;
    while (!(run_idx == 1 && tmr_rst_n) && n < 1000) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("reached_run2_wait", {31'b0, run_idx == 1 && tmr_rst_n}, 32'd1);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_tmr_rst_n", {31'b0, tmr_rst_n}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_res_valid", {31'b0, res_valid}, 32'd0);
    rst_n = 1'b1;
    push_rec(4, 10, 70, 160, 40, 1'b0);
    pulse_start();
    wait_done("after_reset", 3000, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
